// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port integer register file with
// write-through bypass and a per-register pending-write scoreboard.
module regfile_mp_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int PW       = 2,
  parameter int SP_IDX   = 2,
  parameter int SP_INIT  = 2048,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic                iss_stall,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data,
  output logic                err_uflow
);

  localparam logic [PW-1:0] CMAX = '1;

  logic [XLEN-1:0] regs [NREG];
  logic [PW-1:0]   cnt  [NREG];

  logic [AW-1:0]   wa   [NWR];
  logic [XLEN-1:0] wd   [NWR];
  logic [AW-1:0]   ra   [NRD];

  logic [NREG-1:0] hit;
  logic [NREG-1:0] dec;
  logic [NREG-1:0] inc;
  logic [NREG-1:0] uflow;
  logic [XLEN-1:0] wval [NREG];

  // Unpack the flat port buses into per-port addresses and data
  always_comb begin
    for (int q = 0; q < NWR; q++) begin
      wa[q] = wr_addr[q*AW +: AW];
      wd[q] = wr_data[q*XLEN +: XLEN];
    end
    for (int p = 0; p < NRD; p++) begin
      ra[p] = rd_addr[p*AW +: AW];
    end
  end

  // Per-register write match; later (higher) ports override earlier ones
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      hit[r]  = 1'b0;
      wval[r] = '0;
    end
    for (int r = 1; r < NREG; r++) begin
      for (int q = 0; q < NWR; q++) begin
        if (wr_en[q] && (wa[q] == AW'(r))) begin
          hit[r]  = 1'b1;
          wval[r] = wd[q];
        end
      end
    end
  end

  // A retiring write to the issue target frees a slot this cycle
  always_comb begin
    iss_stall = iss_en
             && (iss_addr != '0)
             && (cnt[iss_addr] == CMAX)
             && !hit[iss_addr];
  end

  // Counter deltas; several writes to one reg retire one reservation
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      dec[r]   = hit[r] && (cnt[r] != '0);
      uflow[r] = hit[r] && (cnt[r] == '0);
      inc[r]   = iss_en
              && !iss_stall
              && (iss_addr == AW'(r))
              && (r != 0);
    end
  end

  // Read ports: bypass from same-cycle writes, x0 reads as zero
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    if (rstn) begin
      for (int p = 0; p < NRD; p++) begin
        rd_busy[p] = (cnt[ra[p]] - PW'(dec[ra[p]])) != '0;
        if (rd_en && (ra[p] != '0)) begin
          rd_data[p*XLEN +: XLEN] = hit[ra[p]] ? wval[ra[p]]
                                               : regs[ra[p]];
        end
      end
    end
  end

  // State update: data, pending counters, debug snapshot, sticky error
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= (r == SP_IDX) ? XLEN'(SP_INIT) : '0;
        cnt[r]  <= '0;
      end
      dbg_data  <= '0;
      err_uflow <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (hit[r]) begin
          regs[r] <= wval[r];
        end
        cnt[r] <= cnt[r] + PW'(inc[r]) - PW'(dec[r]);
      end
      dbg_data <= regs[dbg_addr];
      if (|uflow) begin
        err_uflow <= 1'b1;
      end
    end
  end

endmodule
